// File: rtl/slc3_mem_arbiter.sv
// slc3_mem_arbiter: two-port sequencer for the SLC-3 asynchronous SRAM.
// Port 0 is the CPU MAR/MDR path, port 1 the debug/front-panel loader.
// Each access runs IDLE -> SETUP -> ACCESS (WAIT_CYCLES) -> DONE.
// Optional macro SLC3_ARB_ROUND_ROBIN_EN: round-robin conflict resolution;
// when undefined, port 0 wins every conflict.
module slc3_mem_arbiter #(
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              gnt_id,
  output logic [ADDR_W-1:0] ADDR,
  output logic [DATA_W-1:0] sram_dout,
  input  logic [DATA_W-1:0] sram_din,
  output logic              sram_oe_dq,
  output logic              CE_N,
  output logic              OE_N,
  output logic              WE_N,
  output logic              UB_N,
  output logic              LB_N
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_DONE} state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  localparam logic [3:0] WLOAD = 4'(WAIT_CYCLES - 1);

  state_t     state, nxt;
  logic [3:0] wcnt;
  logic       any_req;
  logic       grant;
  req_t       req_sel;
  req_t       cur_q;

  assign any_req   = req0 | req1;
  assign req_sel   = grant ? '{we1, addr1, wdata1} : '{we0, addr0, wdata0};
  assign ADDR      = cur_q.addr;
  assign sram_dout = cur_q.wdata;

`ifdef SLC3_ARB_ROUND_ROBIN_EN
  // rr_last = port served most recently; reset value 1 lets port 0 win first
  logic rr_last;
  assign grant = (req0 & req1) ? ~rr_last : ~req0;

  // pointer moves on every grant, contested or not
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)                        rr_last <= 1'b1;
    else if (state == S_IDLE && any_req) rr_last <= grant;
  end
`else
  // fixed priority: port 1 only when port 0 is not asking
  assign grant = ~req0;
`endif

  // state register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= S_IDLE;
    else          state <= nxt;
  end

  // next-state: SETUP and DONE are single cycles, ACCESS runs until wcnt hits 0
  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:   if (any_req) nxt = S_SETUP;
      S_SETUP:  nxt = S_ACCESS;
      S_ACCESS: if (wcnt == 4'd0) nxt = S_DONE;
      S_DONE:   nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  // strobes decode straight from state so a reset releases them at once
  always_comb begin
    CE_N       = 1'b1;
    OE_N       = 1'b1;
    WE_N       = 1'b1;
    sram_oe_dq = 1'b0;
    done0      = 1'b0;
    done1      = 1'b0;
    busy       = (state != S_IDLE);
    unique case (state)
      S_SETUP: begin
        CE_N       = 1'b0;
        sram_oe_dq = cur_q.we;
      end
      S_ACCESS: begin
        CE_N       = 1'b0;
        OE_N       = cur_q.we;
        WE_N       = ~cur_q.we;
        sram_oe_dq = cur_q.we;
      end
      S_DONE: begin
        done0 = ~gnt_id;
        done1 = gnt_id;
      end
      default: ;
    endcase
    UB_N = CE_N;
    LB_N = CE_N;
  end

  // request latch, wait counter and read capture
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cur_q  <= '0;
      gnt_id <= 1'b0;
      wcnt   <= 4'd0;
      rdata  <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (any_req) begin
          cur_q  <= req_sel;
          gnt_id <= grant;
        end
        S_SETUP: wcnt <= WLOAD;
        S_ACCESS: begin
          if (wcnt != 4'd0)   wcnt  <= wcnt - 4'd1;
          else if (!cur_q.we) rdata <= sram_din;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_slc3_mem_arbiter.sv
// Randomized scoreboard bench for slc3_mem_arbiter.
// A transaction-level model decides grants from the sampled requests and
// queues the expected completion; an independent monitor checks the bus and
// pops on every done pulse. Two extra instances cover WAIT_CYCLES=1 and 15.
module tb_slc3_mem_arbiter;
  localparam int AW = 20;
  localparam int DW = 16;
  localparam int WC = 2;

  typedef struct {
    int          port;
    bit          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int          dcyc;
  } exp_t;

  logic Clk = 1'b0;
  logic Reset_n = 1'b1;
  always #5 Clk = ~Clk;

  logic          rq [2];
  logic          wq [2];
  logic [AW-1:0] aq [2];
  logic [DW-1:0] dq [2];

  logic          done0, done1, busy, gnt_id, sram_oe_dq;
  logic          CE_N, OE_N, WE_N, UB_N, LB_N;
  logic [DW-1:0] rdata, sram_dout, sram_din;
  logic [AW-1:0] ADDR;

  slc3_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WC)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .req0(rq[0]), .req1(rq[1]), .we0(wq[0]), .we1(wq[1]),
    .addr0(aq[0]), .addr1(aq[1]), .wdata0(dq[0]), .wdata1(dq[1]),
    .done0(done0), .done1(done1), .rdata(rdata), .busy(busy), .gnt_id(gnt_id),
    .ADDR(ADDR), .sram_dout(sram_dout), .sram_din(sram_din), .sram_oe_dq(sram_oe_dq),
    .CE_N(CE_N), .OE_N(OE_N), .WE_N(WE_N), .UB_N(UB_N), .LB_N(LB_N)
  );

  // latency-only instances: index 0 -> WAIT_CYCLES=1, index 1 -> 15
  logic          x_req;
  logic          x_done0 [2], x_done1 [2], x_busy [2], x_gnt [2], x_oedq [2];
  logic          x_ce [2], x_oe [2], x_we [2], x_ub [2], x_lb [2];
  logic [DW-1:0] x_rdata [2], x_dout [2];
  logic [AW-1:0] x_addr [2];

  for (genvar g = 0; g < 2; g++) begin : g_wc
    slc3_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(g == 0 ? 1 : 15)) u (
      .Clk(Clk), .Reset_n(Reset_n),
      .req0(x_req), .req1(1'b0), .we0(1'b0), .we1(1'b0),
      .addr0(20'h00055), .addr1(20'h0), .wdata0(16'h0), .wdata1(16'h0),
      .done0(x_done0[g]), .done1(x_done1[g]), .rdata(x_rdata[g]), .busy(x_busy[g]),
      .gnt_id(x_gnt[g]), .ADDR(x_addr[g]), .sram_dout(x_dout[g]), .sram_din(16'hA5A5),
      .sram_oe_dq(x_oedq[g]), .CE_N(x_ce[g]), .OE_N(x_oe[g]), .WE_N(x_we[g]),
      .UB_N(x_ub[g]), .LB_N(x_lb[g])
    );
  end

  // SRAM contents before any write: 0x10 holds 0xBEEF, others a pattern
  function automatic logic [DW-1:0] init_val(input logic [7:0] a);
    return (a == 8'h10) ? 16'hBEEF : {a, ~a};
  endfunction

  // behavioural SRAM on the main instance
  logic [DW-1:0] mem [256];
  bit            mem_wr [256];
  always @(posedge Clk)
    if (!CE_N && !WE_N && sram_oe_dq) begin
      mem[ADDR[7:0]]    <= sram_dout;
      mem_wr[ADDR[7:0]] <= 1'b1;
    end
  assign sram_din = mem_wr[ADDR[7:0]] ? mem[ADDR[7:0]] : init_val(ADDR[7:0]);

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  exp_t          q [$];
  int            gnt_log [$];
  logic [DW-1:0] ref_mem [256];
  bit            ref_wr [256];
  int            cyc = 0;
  int            next_free = 0;
  int            last_port = 1;
  logic [DW-1:0] last_rd = '0;

  // Each cycle: if the arbiter is free and someone asks, decide who is served,
  // what it returns, and in which cycle the done must show up.
  always @(posedge Clk) begin : model
    exp_t e;
    int   p;
    if (!Reset_n) begin
      next_free = cyc + 1;
      last_port = 1;
      last_rd   = '0;
    end else if (cyc >= next_free && (rq[0] || rq[1])) begin
`ifdef SLC3_ARB_ROUND_ROBIN_EN
      p = (rq[0] && rq[1]) ? 1 - last_port : (rq[0] ? 0 : 1);
`else
      p = rq[0] ? 0 : 1;
`endif
      e.port  = p;
      e.we    = wq[p];
      e.addr  = aq[p];
      e.wdata = dq[p];
      if (e.we) begin
        ref_mem[e.addr[7:0]] = e.wdata;
        ref_wr[e.addr[7:0]]  = 1'b1;
        e.rdata = last_rd;
      end else begin
        e.rdata = ref_wr[e.addr[7:0]] ? ref_mem[e.addr[7:0]] : init_val(e.addr[7:0]);
        last_rd = e.rdata;
      end
      e.dcyc    = cyc + WC + 2;
      next_free = cyc + WC + 3;
      last_port = p;
      q.push_back(e);
    end
    cyc = cyc + 1;
  end

  // ---------------- monitor ----------------
  int we_cnt = 0;
  int oe_cnt = 0;

  always @(negedge Clk) begin : mon
    exp_t e;
    int   dp;
    if (Reset_n) begin
      if (!WE_N) we_cnt++;
      if (!OE_N) oe_cnt++;
      if (q.size() > 0 && cyc > q[0].dcyc) begin
        checks++; errors++;
        $display("FAIL late_done cyc=%0d port=%0d required by cyc %0d", cyc, q[0].port, q[0].dcyc);
        void'(q.pop_front());
        we_cnt = 0; oe_cnt = 0;
      end
      if (busy) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL busy_idle cyc=%0d busy=1 required 0", cyc);
        end else if (ADDR !== q[0].addr || gnt_id !== 1'(q[0].port) ||
                     (q[0].we && sram_dout !== q[0].wdata) || (!WE_N && !sram_oe_dq)) begin
          errors++;
          $display("FAIL bus_hold cyc=%0d ADDR=%h gnt=%b dout=%h oedq=%b required ADDR=%h gnt=%0d dout=%h",
                   cyc, ADDR, gnt_id, sram_dout, sram_oe_dq, q[0].addr, q[0].port, q[0].wdata);
        end
      end
      if (done0 || done1) begin
        checks++;
        dp = done1 ? 1 : 0;
        gnt_log.push_back(dp);
        if (q.size() == 0) begin
          errors++;
          $display("FAIL spurious_done cyc=%0d done0=%b done1=%b required none", cyc, done0, done1);
        end else begin
          e = q.pop_front();
          if ((done0 && done1) || dp != e.port || cyc != e.dcyc || rdata !== e.rdata ||
              we_cnt != (e.we ? WC : 0) || oe_cnt != (e.we ? 0 : WC)) begin
            errors++;
            $display("FAIL done cyc=%0d port=%0d rdata=%h we_lo=%0d oe_lo=%0d required cyc=%0d port=%0d rdata=%h we_lo=%0d oe_lo=%0d",
                     cyc, dp, rdata, we_cnt, oe_cnt, e.dcyc, e.port, e.rdata,
                     e.we ? WC : 0, e.we ? 0 : WC);
          end
        end
        we_cnt = 0; oe_cnt = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  // n transactions on port p; with hold the request stays high into the next
  // one, otherwise it drops the cycle after done for at least one cycle
  task automatic drive(input int p, input int n, input bit rnd, input bit hold,
                       input logic [AW-1:0] a0, input logic [DW-1:0] d0, input bit w0);
    for (int i = 0; i < n; i++) begin
      int to;
      bit h;
      h = rnd ? 1'($urandom_range(0, 1)) : hold;
      if (rnd) begin
        wq[p] = 1'($urandom_range(0, 1));
        aq[p] = (20'($urandom()) & 20'hFFF00) | 20'($urandom_range(0, 15));
        dq[p] = 16'($urandom());
      end else begin
        wq[p] = w0;
        aq[p] = a0 + 20'(i);
        dq[p] = d0 + 16'(i);
      end
      rq[p] = 1'b1;
      to = 0;
      do begin
        @(negedge Clk);
        to++;
      end while (!(p == 0 ? done0 : done1) && to < 400);
      if (to >= 400) begin
        checks++; errors++;
        $display("FAIL timeout port=%0d no done within 400 cycles", p);
        rq[p] = 1'b0;
        return;
      end
      @(posedge Clk); #1;
      if (!h || i == n - 1) begin
        rq[p] = 1'b0;
        if (i < n - 1) repeat (1 + $urandom_range(0, 2)) begin @(posedge Clk); #1; end
      end
    end
  endtask

  task automatic check_log(input string name, input int exp_seq [$]);
    checks++;
    if (gnt_log != exp_seq) begin
      errors++;
      $display("FAIL %s grant order got %p required %p", name, gnt_log, exp_seq);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got %h required %h", name, got, req);
    end
  endtask

  initial begin : main
    int to, n1, n15;
    logic [DW-1:0] r1, r15;
    int seq [$];
    for (int i = 0; i < 2; i++) begin
      rq[i] = 1'b0; wq[i] = 1'b0; aq[i] = '0; dq[i] = '0;
    end
    x_req = 1'b0;

    // reset state
    #1 Reset_n = 1'b0;
    #2;
    chk("reset_ctl", {22'd0, CE_N, OE_N, WE_N, UB_N, LB_N, sram_oe_dq, done0, done1, busy, gnt_id},
        32'b11111_00000);
    chk("reset_addr", 32'(ADDR), 32'd0);
    chk("reset_dout", 32'(sram_dout), 32'd0);
    chk("reset_rdata", 32'(rdata), 32'd0);
    repeat (2) @(posedge Clk);
    #1 Reset_n = 1'b1;
    repeat (2) @(posedge Clk);
    #1;

    // single read on port 0, then single write on port 1
    drive(0, 1, 1'b0, 1'b0, 20'h00010, 16'h0, 1'b0);
    chk("read_rdata", 32'(rdata), 32'h0000BEEF);
    drive(1, 1, 1'b0, 1'b0, 20'h00020, 16'h1234, 1'b1);

    // both ports held busy for three transactions each
    gnt_log.delete();
    fork
      drive(0, 3, 1'b0, 1'b1, 20'h00030, 16'h1000, 1'b1);
      drive(1, 3, 1'b0, 1'b1, 20'h00040, 16'h2000, 1'b1);
    join
`ifdef SLC3_ARB_ROUND_ROBIN_EN
    seq = '{0, 1, 0, 1, 0, 1};
`else
    seq = '{0, 0, 0, 1, 1, 1};
`endif
    check_log("conflict", seq);

    // port 1 arrives while port 0 is in ACCESS
    repeat (2) @(posedge Clk);
    #1;
    gnt_log.delete();
    fork
      drive(0, 1, 1'b0, 1'b0, 20'h00031, 16'h0, 1'b0);
      begin
        repeat (3) @(posedge Clk);
        #1;
        drive(1, 1, 1'b0, 1'b0, 20'h00020, 16'h0, 1'b0);
      end
    join
    seq = '{0, 1};
    check_log("late_req1", seq);

    // reset during a write's ACCESS phase
    repeat (2) @(posedge Clk);
    #1;
    wq[0] = 1'b1; aq[0] = 20'h000FF; dq[0] = 16'hCAFE; rq[0] = 1'b1;
    to = 0;
    do begin
      @(negedge Clk);
      to++;
    end while (WE_N && to < 50);
    chk("abort_reach_access", 32'(to < 50), 32'd1);
    #2;
    Reset_n = 1'b0;
    q.delete();
    we_cnt = 0; oe_cnt = 0;
    #1;
    chk("abort_strobes", {29'd0, WE_N, CE_N, OE_N}, 32'b111);
    chk("abort_busy_done", {29'd0, busy, done0, done1}, 32'b000);
    chk("abort_oedq", 32'(sram_oe_dq), 32'd0);
    rq[0] = 1'b0;
    repeat (2) @(posedge Clk);
    #1 Reset_n = 1'b1;
    @(posedge Clk);
    #1;
    drive(0, 1, 1'b0, 1'b0, 20'h00020, 16'h0, 1'b0);
    chk("after_abort_rdata", 32'(rdata), 32'h00001234);

    // WAIT_CYCLES = 1 and 15 latency
    x_req = 1'b1;
    n1 = -1; n15 = -1; r1 = '0; r15 = '0;
    for (int k = 0; k < 40; k++) begin
      @(negedge Clk);
      if (x_done0[0] && n1 < 0)  begin n1  = k; r1  = x_rdata[0]; end
      if (x_done0[1] && n15 < 0) begin n15 = k; r15 = x_rdata[1]; end
    end
    x_req = 1'b0;
    chk("wc1_latency", 32'(n1), 32'd3);
    chk("wc15_latency", 32'(n15), 32'd17);
    chk("wc1_rdata", 32'(r1), 32'h0000A5A5);
    chk("wc15_rdata", 32'(r15), 32'h0000A5A5);

    // randomized traffic on both ports
    @(posedge Clk);
    #1;
    fork
      drive(0, 25, 1'b1, 1'b0, 20'h0, 16'h0, 1'b0);
      drive(1, 25, 1'b1, 1'b0, 20'h0, 16'h0, 1'b0);
    join
    repeat (10) @(posedge Clk);
    #1;
    chk("drained", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
